ddr3_app_arbiter: RTL and testbench
===================================

# ddr3_app_arbiter

Two-port arbiter that shares the single user-side command/write-data port of the DDR3 memory interface between two requesters (e.g. the traffic generator and a video/DMA engine). It sits in the `clk_x1` domain between the requesters and the DDR3 controller, grants whole commands using run-limited round-robin, and steers in-order read data back to the issuing port through a tag FIFO.

## Interface

- ADDR_WIDTH, 29, app address width
- APP_DATA_WIDTH, 256, data width per command (one BL8 beat on x32)
- APP_MASK_WIDTH, 32, write byte-mask width
- MAX_RUN, 8, max consecutive grants to one port while the other waits (≥1)
- TAG_DEPTH, 16, outstanding-read tag FIFO depth (power of two)

Ports (N ∈ {0,1}, one full set per requester):

- clk  in  1  controller user clock (`clk_x1`)
- rst  in  1  reset, synchronous, active-high
- init_calib_complete  in  1  controller ready
- mN_req  in  1  command valid, held until ack
- mN_cmd  in  3  0 = write, 1 = read (controller encoding)
- mN_addr  in  ADDR_WIDTH  command address
- mN_wr_data  in  APP_DATA_WIDTH  write data, valid with mN_req when cmd = write
- mN_wr_mask  in  APP_MASK_WIDTH  write mask
- mN_ack  out  1  command accepted this cycle
- mN_rd_valid  out  1  read data for port N on rd_data
- rd_data  out  APP_DATA_WIDTH  broadcast read data
- app_rdy  in  1  controller cmd_ready
- app_wdf_rdy  in  1  controller wr_data_rdy
- app_en, app_cmd, app_addr  out  1/3/ADDR_WIDTH  to controller
- app_wdf_wren, app_wdf_end  out  1  write strobe/end (equal)
- app_wdf_data, app_wdf_mask  out  APP_DATA_WIDTH/APP_MASK_WIDTH
- app_rd_data_valid, app_rd_data  in  1/APP_DATA_WIDTH  from controller
- rd_err  out  1  sticky: read data returned with empty tag FIFO

## Operation

- FSM states IDLE, OWN0, OWN1; run counter `run` (clog2(MAX_RUN+1) bits).
- Eligible(N) = mN_req & init_calib_complete & app_rdy & (cmd==read ? tag FIFO not full : app_wdf_rdy).
- IDLE: pick port 1 if only it is eligible, else port 0 if eligible; next state OWNx, run=1 on issue.
- OWNx: if x eligible and (run<MAX_RUN or other not requesting) → issue x, run+1 (saturating). Else if other eligible → issue other, switch state, run=1. Else if neither requests → IDLE.
- Issue: app_en=1, app_cmd/app_addr muxed from winner; mN_ack=1 for winner only; for write, app_wdf_wren=app_wdf_end=1 same cycle with data/mask. For read, push tag N.
- Read return: on app_rd_data_valid pop tag; mN_rd_valid = valid & (head==N); rd_data = app_rd_data. Pop with empty FIFO → no rd_valid, set rd_err.
- Push when full is impossible by eligibility (no push on full even with concurrent pop). Simultaneous push and pop keeps count.
- Unsupported cmd codes treated as read.

## Timing

- Ack/app_en combinational from registered state and current inputs; zero-cycle issue latency.
- Read data to mN_rd_valid: combinational, zero added latency.
- Reset values: state IDLE, run 0, FIFO empty, rd_err 0; all app_* enables and mN_ack/mN_rd_valid 0.
- Reset mid-traffic flushes tags; in-flight read returns afterwards set rd_err.
- init_calib_complete low: no issue, state frozen.

## Structure

- Package `ddr3_arb_pkg`: command encodings CMD_WR=3'd0, CMD_RD=3'd1, state enum.
- Sub-module `ddr3_tag_fifo` (width 1, depth TAG_DEPTH, full/empty/count).

## Test plan

- Both ports issue continuous writes, all ready → grants alternate in runs of 8 (MAX_RUN), ack counts equal ±8.
- Only m1 reads 20 times, model returns in order → 20 m1_rd_valid, zero m0_rd_valid, data matches.
- Interleaved reads 0,1,1,0 → rd_valid routed 0,1,1,0; FIFO empty after.
- 16 outstanding reads, 17th read request → no ack until one return; write from other port still acks.
- app_wdf_rdy low with write pending, other port read → read issues, write waits, no app_wdf_wren.
- app_rd_data_valid with empty FIFO → rd_err=1 held until rst.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared definitions for the DDR3 application-port arbiter: controller command
// encodings and the arbitration state type.
package ddr3_arb_pkg;

  localparam logic [2:0] CMD_WR = 3'd0;
  localparam logic [2:0] CMD_RD = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Anything that is not a write is issued and tracked as a read.
  function automatic logic is_read(input logic [2:0] cmd);
    return (cmd != CMD_WR);
  endfunction

endpackage

// File: rtl/ddr3_tag_fifo.sv
// One-bit-wide tag FIFO recording which port issued each outstanding read,
// popped in order as read data returns from the controller.
module ddr3_tag_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       din,
  input  logic                       pop,
  output logic                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage, pointers and occupancy; pointers wrap naturally on a power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r    <= {DEPTH{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});
  assign count = count_r;

endmodule

// File: rtl/ddr3_app_arbiter.sv
// Shares the DDR3 app command/write-data port between two requesters using
// run-limited round-robin; read data is steered back through an in-order tag FIFO.
module ddr3_app_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 29,
  parameter int APP_DATA_WIDTH = 256,
  parameter int APP_MASK_WIDTH = 32,
  parameter int MAX_RUN        = 8,
  parameter int TAG_DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init_calib_complete,
  input  logic                      m0_req,
  input  logic [2:0]                m0_cmd,
  input  logic [ADDR_WIDTH-1:0]     m0_addr,
  input  logic [APP_DATA_WIDTH-1:0] m0_wr_data,
  input  logic [APP_MASK_WIDTH-1:0] m0_wr_mask,
  output logic                      m0_ack,
  output logic                      m0_rd_valid,
  input  logic                      m1_req,
  input  logic [2:0]                m1_cmd,
  input  logic [ADDR_WIDTH-1:0]     m1_addr,
  input  logic [APP_DATA_WIDTH-1:0] m1_wr_data,
  input  logic [APP_MASK_WIDTH-1:0] m1_wr_mask,
  output logic                      m1_ack,
  output logic                      m1_rd_valid,
  output logic [APP_DATA_WIDTH-1:0] rd_data,
  input  logic                      app_rdy,
  input  logic                      app_wdf_rdy,
  output logic                      app_en,
  output logic [2:0]                app_cmd,
  output logic [ADDR_WIDTH-1:0]     app_addr,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
  output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
  input  logic                      app_rd_data_valid,
  input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
  output logic                      rd_err
);

  localparam int               RUN_W   = $clog2(MAX_RUN + 1);
  localparam int               CNT_W   = $clog2(TAG_DEPTH + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  arb_state_e       state_r, state_nxt_s;
  logic [RUN_W-1:0] run_r, run_nxt_s, run_inc_s;
  logic             rd_err_r;
  logic             is_rd0_s, is_rd1_s, elig0_s, elig1_s, grant0_s, grant1_s;
  logic             tag_push_s, tag_head_s, tag_full_s, tag_empty_s;
  logic [CNT_W-1:0] tag_count_s;

  assign is_rd0_s  = is_read(m0_cmd);
  assign is_rd1_s  = is_read(m1_cmd);
  assign elig0_s   = m0_req & init_calib_complete & app_rdy & (is_rd0_s ? ~tag_full_s : app_wdf_rdy);
  assign elig1_s   = m1_req & init_calib_complete & app_rdy & (is_rd1_s ? ~tag_full_s : app_wdf_rdy);
  assign run_inc_s = (run_r < RUN_MAX) ? (run_r + RUN_ONE) : RUN_MAX;

  // Winner selection and next ownership; the owner keeps the port until its run expires
  always_comb begin
    state_nxt_s = state_r;
    run_nxt_s   = run_r;
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    if (!init_calib_complete) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (elig1_s && !elig0_s) begin
            grant1_s = 1'b1; state_nxt_s = ST_OWN1; run_nxt_s = RUN_ONE;
          end else if (elig0_s) begin
            grant0_s = 1'b1; state_nxt_s = ST_OWN0; run_nxt_s = RUN_ONE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_OWN0: begin
          if (elig0_s && ((run_r < RUN_MAX) || !m1_req)) begin
            grant0_s = 1'b1; run_nxt_s = run_inc_s;
          end else if (elig1_s) begin
            grant1_s = 1'b1; state_nxt_s = ST_OWN1; run_nxt_s = RUN_ONE;
          end else if (!m0_req && !m1_req) begin
            state_nxt_s = ST_IDLE; run_nxt_s = {RUN_W{1'b0}};
          end else begin
            state_nxt_s = ST_OWN0;
          end
        end
        ST_OWN1: begin
          if (elig1_s && ((run_r < RUN_MAX) || !m0_req)) begin
            grant1_s = 1'b1; run_nxt_s = run_inc_s;
          end else if (elig0_s) begin
            grant0_s = 1'b1; state_nxt_s = ST_OWN0; run_nxt_s = RUN_ONE;
          end else if (!m0_req && !m1_req) begin
            state_nxt_s = ST_IDLE; run_nxt_s = {RUN_W{1'b0}};
          end else begin
            state_nxt_s = ST_OWN1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE; run_nxt_s = {RUN_W{1'b0}};
        end
      endcase
    end
  end

  // Arbitration state, run length and sticky underflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      run_r    <= {RUN_W{1'b0}};
      rd_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      run_r   <= run_nxt_s;
      if (app_rd_data_valid && (tag_count_s == {CNT_W{1'b0}})) begin
        rd_err_r <= 1'b1;
      end else begin
        rd_err_r <= rd_err_r;
      end
    end
  end

  assign tag_push_s = (grant0_s & is_rd0_s) | (grant1_s & is_rd1_s);

  ddr3_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push_s),
    .din   (grant1_s),
    .pop   (app_rd_data_valid),
    .dout  (tag_head_s),
    .full  (tag_full_s),
    .empty (tag_empty_s),
    .count (tag_count_s)
  );

  assign m0_ack       = grant0_s;
  assign m1_ack       = grant1_s;
  assign app_en       = grant0_s | grant1_s;
  assign app_cmd      = grant1_s ? m1_cmd : m0_cmd;
  assign app_addr     = grant1_s ? m1_addr : m0_addr;
  assign app_wdf_wren = (grant0_s & ~is_rd0_s) | (grant1_s & ~is_rd1_s);
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = grant1_s ? m1_wr_data : m0_wr_data;
  assign app_wdf_mask = grant1_s ? m1_wr_mask : m0_wr_mask;
  assign m0_rd_valid  = app_rd_data_valid & ~tag_empty_s & ~tag_head_s;
  assign m1_rd_valid  = app_rd_data_valid & ~tag_empty_s & tag_head_s;
  assign rd_data      = app_rd_data;
  assign rd_err       = rd_err_r;

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Self-checking bench for ddr3_app_arbiter: a vector table, directed corner
// sequences and random traffic, all checked against a rule-level reference model.
module tb_ddr3_app_arbiter;
  import ddr3_arb_pkg::*;

  localparam int AW = 29, DW = 256, MW = 32, MAXR = 8, TD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic m0_req, m1_req, m0_ack, m1_ack, m0_rd_valid, m1_rd_valid;
  logic [2:0] m0_cmd, m1_cmd, app_cmd;
  logic [AW-1:0] m0_addr, m1_addr, app_addr;
  logic [DW-1:0] m0_wr_data, m1_wr_data, rd_data, app_wdf_data, app_rd_data;
  logic [MW-1:0] m0_wr_mask, m1_wr_mask, app_wdf_mask;
  logic app_en, app_wdf_wren, app_wdf_end, rd_err;

  ddr3_app_arbiter #(.ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW),
                     .MAX_RUN(MAXR), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_wr_mask(m0_wr_mask), .m0_ack(m0_ack), .m0_rd_valid(m0_rd_valid),
    .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_wr_mask(m1_wr_mask), .m1_ack(m1_ack), .m1_rd_valid(m1_rd_valid),
    .rd_data(rd_data), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data), .rd_err(rd_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: current owner (-1 = nobody), run length, outstanding read tags
  int own = -1;
  int run = 0;
  int tagq[$];
  bit err = 1'b0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic bit mrd(logic [2:0] c);
    return c != CMD_WR;
  endfunction

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [2:0] rnd_cmd();
    if ($urandom_range(0, 3) == 0) return 3'($urandom_range(2, 7));
    return ($urandom_range(0, 1) == 1) ? CMD_RD : CMD_WR;
  endfunction

  task automatic drive0(bit req, logic [2:0] cmd);
    m0_req = req; m0_cmd = cmd; m0_addr = AW'($urandom());
    m0_wr_data = rnd256(); m0_wr_mask = $urandom();
  endtask

  task automatic drive1(bit req, logic [2:0] cmd);
    m1_req = req; m1_cmd = cmd; m1_addr = AW'($urandom());
    m1_wr_data = rnd256(); m1_wr_mask = $urandom();
  endtask

  task automatic idle_inputs();
    init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data_valid = 1'b0; app_rd_data = rnd256();
    drive0(1'b0, CMD_WR); drive1(1'b0, CMD_WR);
  endtask

  // Mid-cycle: compare DUT against the model for the current inputs, then advance the model
  task automatic cycle();
    int g, head;
    bit el[2], rq[2], rd[2];
    #4;
    if (rst) begin
      own = -1; run = 0; tagq.delete(); err = 1'b0;
    end else begin
      rq[0] = m0_req; rq[1] = m1_req;
      rd[0] = mrd(m0_cmd); rd[1] = mrd(m1_cmd);
      for (int n = 0; n < 2; n++)
        el[n] = rq[n] && init_calib_complete && app_rdy &&
                (rd[n] ? (tagq.size() < TD) : app_wdf_rdy);
      g = -1;
      if (init_calib_complete) begin
        if (own < 0) g = (el[1] && !el[0]) ? 1 : (el[0] ? 0 : -1);
        else if (el[own] && (run < MAXR || !rq[1-own])) g = own;
        else if (el[1-own]) g = 1 - own;
        else if (!rq[0] && !rq[1]) own = -1;
      end
      head = (app_rd_data_valid && tagq.size() > 0) ? tagq[0] : -1;
      chk("m0_ack", m0_ack, g == 0);
      chk("m1_ack", m1_ack, g == 1);
      chk("app_en", app_en, g >= 0);
      chk("app_wdf_wren", app_wdf_wren, (g >= 0) ? !rd[g] : 1'b0);
      chk("app_wdf_end", app_wdf_end, (g >= 0) ? !rd[g] : 1'b0);
      if (g >= 0) begin
        chk("app_cmd", app_cmd, (g == 1) ? m1_cmd : m0_cmd);
        chk("app_addr", app_addr, (g == 1) ? m1_addr : m0_addr);
        if (!rd[g]) begin
          chk("app_wdf_data", app_wdf_data, (g == 1) ? m1_wr_data : m0_wr_data);
          chk("app_wdf_mask", app_wdf_mask, (g == 1) ? m1_wr_mask : m0_wr_mask);
        end
      end
      chk("m0_rd_valid", m0_rd_valid, head == 0);
      chk("m1_rd_valid", m1_rd_valid, head == 1);
      chk("rd_data", rd_data, app_rd_data);
      chk("rd_err", rd_err, err);
      if (app_rd_data_valid) begin
        if (tagq.size() > 0) void'(tagq.pop_front());
        else err = 1'b1;
      end
      if (g >= 0) begin
        if (rd[g]) tagq.push_back(g);
        run = (g == own) ? ((run < MAXR) ? run + 1 : run) : 1;
        own = g;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic step();
    cycle(); adv();
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_inputs(); step(); step(); rst = 1'b0;
  endtask

  typedef struct {
    bit calib, rdy, wrdy, q0, q1;
    logic [2:0] c0, c1;
    bit e0, e1, ew;
  } vec_t;

  vec_t tbl[12];
  int exp_route[5];
  int ord[4];
  int cnt0, cnt1, runlen, maxrun, prev, cur, issued, pend, nv0, nv1, d;

  initial begin
    rst = 1'b1; idle_inputs();
    // From IDLE: hand-derived grants for calib/ready gating, ownership and odd read codes
    tbl[0]  = '{calib:1, rdy:1, wrdy:1, q0:0, q1:0, c0:CMD_WR, c1:CMD_WR, e0:0, e1:0, ew:0};
    tbl[1]  = '{calib:0, rdy:1, wrdy:1, q0:1, q1:1, c0:CMD_WR, c1:CMD_WR, e0:0, e1:0, ew:0};
    tbl[2]  = '{calib:1, rdy:0, wrdy:1, q0:1, q1:1, c0:CMD_WR, c1:CMD_WR, e0:0, e1:0, ew:0};
    tbl[3]  = '{calib:1, rdy:1, wrdy:1, q0:1, q1:1, c0:CMD_WR, c1:CMD_WR, e0:1, e1:0, ew:1};
    tbl[4]  = '{calib:1, rdy:1, wrdy:1, q0:0, q1:1, c0:CMD_WR, c1:CMD_RD, e0:0, e1:1, ew:0};
    tbl[5]  = '{calib:1, rdy:1, wrdy:0, q0:1, q1:1, c0:CMD_WR, c1:CMD_RD, e0:0, e1:1, ew:0};
    tbl[6]  = '{calib:1, rdy:1, wrdy:0, q0:1, q1:0, c0:CMD_WR, c1:CMD_RD, e0:0, e1:0, ew:0};
    tbl[7]  = '{calib:1, rdy:1, wrdy:1, q0:1, q1:0, c0:CMD_WR, c1:CMD_RD, e0:1, e1:0, ew:1};
    tbl[8]  = '{calib:1, rdy:1, wrdy:1, q0:1, q1:0, c0:3'd5,   c1:CMD_WR, e0:1, e1:0, ew:0};
    tbl[9]  = '{calib:1, rdy:1, wrdy:1, q0:0, q1:1, c0:CMD_WR, c1:3'd7,   e0:0, e1:1, ew:0};
    tbl[10] = '{calib:1, rdy:1, wrdy:1, q0:0, q1:0, c0:CMD_WR, c1:CMD_WR, e0:0, e1:0, ew:0};
    tbl[11] = '{calib:1, rdy:1, wrdy:1, q0:1, q1:1, c0:CMD_RD, c1:CMD_RD, e0:1, e1:0, ew:0};
    exp_route = '{1, 1, 0, 1, 0};
    ord = '{0, 1, 1, 0};
    adv();
    do_reset();

    // Reset state
    cycle();
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_rd_err", rd_err, 1'b0);
    chk("rst_wren", app_wdf_wren, 1'b0);
    adv();

    for (int i = 0; i < 12; i++) begin
      init_calib_complete = tbl[i].calib; app_rdy = tbl[i].rdy; app_wdf_rdy = tbl[i].wrdy;
      drive0(tbl[i].q0, tbl[i].c0); drive1(tbl[i].q1, tbl[i].c1);
      cycle();
      chk($sformatf("tbl%0d_ack0", i), m0_ack, tbl[i].e0);
      chk($sformatf("tbl%0d_ack1", i), m1_ack, tbl[i].e1);
      chk($sformatf("tbl%0d_wren", i), app_wdf_wren, tbl[i].ew);
      adv();
    end
    // Drain the table's reads: tags were pushed as 1,1,0,1,0
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      app_rd_data_valid = 1'b1; app_rd_data = rnd256();
      cycle();
      chk($sformatf("route%0d_rv0", i), m0_rd_valid, exp_route[i] == 0);
      chk($sformatf("route%0d_rv1", i), m1_rd_valid, exp_route[i] == 1);
      adv();
    end

    // Both ports streaming writes: runs of MAX_RUN alternate
    do_reset();
    cnt0 = 0; cnt1 = 0; runlen = 0; maxrun = 0; prev = -1;
    for (int i = 0; i < 48; i++) begin
      drive0(1'b1, CMD_WR); drive1(1'b1, CMD_WR);
      cycle();
      if (m0_ack || m1_ack) begin
        cur = m1_ack ? 1 : 0;
        runlen = (cur == prev) ? runlen + 1 : 1;
        prev = cur;
        if (runlen > maxrun) maxrun = runlen;
        if (cur == 1) cnt1++; else cnt0++;
      end
      adv();
    end
    chk("wr_max_run", maxrun, MAXR);
    chk("wr_total", cnt0 + cnt1, 48);
    chk("wr_balance", ((cnt0 > cnt1) ? cnt0 - cnt1 : cnt1 - cnt0) <= MAXR, 1'b1);

    // m1 issues 20 reads, controller returns them in order
    do_reset();
    issued = 0; pend = 0; nv0 = 0; nv1 = 0;
    for (int i = 0; i < 60; i++) begin
      drive1(issued < 20, CMD_RD);
      app_rd_data_valid = (pend >= 2) || (issued == 20 && pend > 0);
      app_rd_data = rnd256();
      cycle();
      if (m1_rd_valid) nv1++;
      if (m0_rd_valid) nv0++;
      if (m1_ack) begin issued++; pend++; end
      if (app_rd_data_valid) pend--;
      adv();
    end
    chk("m1_reads_issued", issued, 20);
    chk("m1_rd_valid_count", nv1, 20);
    chk("m0_rd_valid_count", nv0, 0);

    // Interleaved reads 0,1,1,0, then an extra return on an empty FIFO
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive0(ord[k] == 0, CMD_RD); drive1(ord[k] == 1, CMD_RD);
      cycle();
      chk($sformatf("il%0d_ack", k), ord[k] ? m1_ack : m0_ack, 1'b1);
      adv();
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      app_rd_data_valid = 1'b1;
      cycle();
      chk($sformatf("il%0d_rv0", k), m0_rd_valid, ord[k] == 0);
      chk($sformatf("il%0d_rv1", k), m1_rd_valid, ord[k] == 1);
      adv();
    end
    cycle();
    chk("empty_pop_rv", m0_rd_valid | m1_rd_valid, 1'b0);
    adv();
    app_rd_data_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle(); chk("rd_err_sticky", rd_err, 1'b1); adv();
    end
    do_reset();
    cycle(); chk("rd_err_cleared", rd_err, 1'b0); adv();

    // Tag FIFO full: 17th read stalls, other port's write still issues
    do_reset();
    cnt0 = 0;
    for (int i = 0; i < TD; i++) begin
      drive0(1'b1, CMD_RD); cycle(); if (m0_ack) cnt0++; adv();
    end
    chk("full_acks", cnt0, TD);
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, CMD_RD); drive1(1'b1, CMD_WR);
      cycle();
      chk("full_rd_blocked", m0_ack, 1'b0);
      chk("full_wr_ack", m1_ack, 1'b1);
      adv();
    end
    drive1(1'b0, CMD_WR); app_rd_data_valid = 1'b1;
    cycle(); chk("full_pop_cycle", m0_ack, 1'b0); adv();
    app_rd_data_valid = 1'b0;
    cycle(); chk("full_after_pop", m0_ack, 1'b1); adv();

    // Write blocked by app_wdf_rdy while the other port reads
    do_reset();
    app_wdf_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, CMD_WR); drive1(1'b1, CMD_RD);
      cycle();
      chk("wdf_rd_ack", m1_ack, 1'b1);
      chk("wdf_wr_wait", m0_ack, 1'b0);
      chk("wdf_no_wren", app_wdf_wren, 1'b0);
      adv();
    end
    app_wdf_rdy = 1'b1; drive1(1'b0, CMD_RD);
    cycle(); chk("wdf_wr_go", m0_ack & app_wdf_wren, 1'b1); adv();

    // Reset with reads in flight: late return flags rd_err
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, CMD_RD); step();
    end
    rst = 1'b1; idle_inputs(); step(); rst = 1'b0;
    app_rd_data_valid = 1'b1;
    cycle(); chk("flush_no_rv", m0_rd_valid | m1_rd_valid, 1'b0); adv();
    app_rd_data_valid = 1'b0;
    cycle(); chk("flush_rd_err", rd_err, 1'b1); adv();

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      init_calib_complete = ($urandom_range(0, 9) != 0);
      app_rdy = ($urandom_range(0, 4) != 0);
      app_wdf_rdy = ($urandom_range(0, 4) != 0);
      drive0($urandom_range(0, 9) < 6, rnd_cmd());
      drive1($urandom_range(0, 9) < 6, rnd_cmd());
      d = (tagq.size() > 0) ? 10 : 50;
      app_rd_data_valid = (d == 10) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      app_rd_data = rnd256();
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
